// File: rtl/mac_pkg.sv
// Shared state type, width helpers and saturation bounds for the mac_dot_array datapath.
package mac_pkg;

  typedef enum logic [1:0] {
    ACC   = 2'd0,
    DRAIN = 2'd1,
    OUT   = 2'd2
  } mac_state_e;

  // Signed product of two DATA_W+1 operands.
  function automatic int prod_width(input int data_w);
    return 2 * data_w + 2;
  endfunction

  function automatic int tree_width(input int data_w, input int lanes);
    return prod_width(data_w) + $clog2(lanes);
  endfunction

  function automatic logic signed [63:0] sat_max(input int acc_w);
    return (64'sd1 <<< (acc_w - 1)) - 64'sd1;
  endfunction

  function automatic logic signed [63:0] sat_min(input int acc_w);
    return -(64'sd1 <<< (acc_w - 1));
  endfunction

endpackage

// File: rtl/mac_dot_adder_tree.sv
// Signed LANES-input reduction of the stage-1 products, registered as pipeline stage 2.
module mac_dot_adder_tree
  import mac_pkg::*;
#(
  parameter int LANES  = 4,
  parameter int DATA_W = 8
) (
  input  logic                                      clock,
  input  logic                                      reset,
  input  logic [LANES*prod_width(DATA_W)-1:0]       prod_i,
  output logic [tree_width(DATA_W, LANES)-1:0]      sum_o
);

  localparam int PROD_W = prod_width(DATA_W);
  localparam int TREE_W = tree_width(DATA_W, LANES);

  // Heap-ordered tree: leaves at [LANES, 2*LANES-1], root at 1.
  logic [TREE_W-1:0] node [1:2*LANES-1];
  logic [TREE_W-1:0] sum_q;

  always_comb begin
    node = '{default: '0};
    for (int i = 0; i < LANES; i++) begin
      node[LANES+i] = TREE_W'($signed(prod_i[i*PROD_W +: PROD_W]));
    end
    for (int k = LANES - 1; k >= 1; k--) begin
      node[k] = node[2*k] + node[2*k+1];
    end
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      sum_q <= '0;
    end else begin
      sum_q <= node[1];
    end
  end

  assign sum_o = sum_q;

endmodule

// File: rtl/mac_dot_array.sv
// Multi-lane uint8 x (u)int8 dot-product accumulator: products, adder tree, accumulator.
// Optional feature macro MAC_SATURATE_EN: clamp each accumulate and report out_overflow.
module mac_dot_array
  import mac_pkg::*;
#(
  parameter int LANES  = 4,
  parameter int DATA_W = 8,
  parameter int ACC_W  = 32
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [LANES*DATA_W-1:0] in_data,
  input  logic [LANES*DATA_W-1:0] in_weight,
  input  logic                    weight_signed,
  input  logic                    in_last,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [ACC_W-1:0]        out_acc,
  output logic                    out_overflow
);

  localparam int PROD_W = prod_width(DATA_W);
  localparam int TREE_W = tree_width(DATA_W, LANES);

  mac_state_e              state_q;
  logic                    in_ready_q, out_valid_q, first_q;
  logic                    accept;
  logic [LANES*PROD_W-1:0] prod_d, prod_q;
  logic                    s1_valid_q, s1_last_q, s1_first_q;
  logic                    s2_valid_q, s2_last_q, s2_first_q;
  logic                    acc_last_q;
  logic [TREE_W-1:0]       tree_sum;
  logic [ACC_W-1:0]        sum_ext, acc_base, acc_d, acc_q;

  assign accept = in_valid && in_ready_q;

  generate
    for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
      logic [DATA_W:0] act_ext, wgt_ext;
      assign act_ext = {1'b0, in_data[gi*DATA_W +: DATA_W]};
      assign wgt_ext = {weight_signed & in_weight[gi*DATA_W + DATA_W - 1],
                        in_weight[gi*DATA_W +: DATA_W]};
      assign prod_d[gi*PROD_W +: PROD_W] = PROD_W'($signed(act_ext)) * PROD_W'($signed(wgt_ext));
    end
  endgenerate

  // Beat flags travel alongside the data so stage 3 knows where a vector starts and ends.
  always_ff @(posedge clock) begin
    if (!reset) begin
      prod_q     <= '0;
      s1_valid_q <= 1'b0;
      s1_last_q  <= 1'b0;
      s1_first_q <= 1'b0;
      s2_valid_q <= 1'b0;
      s2_last_q  <= 1'b0;
      s2_first_q <= 1'b0;
      acc_last_q <= 1'b0;
    end else begin
      s1_valid_q <= accept;
      if (accept) begin
        prod_q     <= prod_d;
        s1_last_q  <= in_last;
        s1_first_q <= first_q;
      end
      s2_valid_q <= s1_valid_q;
      s2_last_q  <= s1_last_q;
      s2_first_q <= s1_first_q;
      acc_last_q <= s2_valid_q && s2_last_q;
    end
  end

  mac_dot_adder_tree #(
    .LANES  (LANES),
    .DATA_W (DATA_W)
  ) u_tree (
    .clock  (clock),
    .reset  (reset),
    .prod_i (prod_q),
    .sum_o  (tree_sum)
  );

  assign sum_ext  = ACC_W'($signed(tree_sum));
  assign acc_base = s2_first_q ? '0 : acc_q;

`ifdef MAC_SATURATE_EN
  localparam logic [ACC_W-1:0] SAT_MAX = ACC_W'(sat_max(ACC_W));
  localparam logic [ACC_W-1:0] SAT_MIN = ACC_W'(sat_min(ACC_W));

  logic [ACC_W:0] acc_wide;
  logic           clamp;
  logic           ovf_q;

  assign acc_wide = {acc_base[ACC_W-1], acc_base} + {sum_ext[ACC_W-1], sum_ext};
  assign clamp    = acc_wide[ACC_W] != acc_wide[ACC_W-1];
  assign acc_d    = !clamp ? acc_wide[ACC_W-1:0] : (acc_wide[ACC_W] ? SAT_MIN : SAT_MAX);

  always_ff @(posedge clock) begin
    if (!reset) begin
      ovf_q <= 1'b0;
    end else if (s2_valid_q) begin
      ovf_q <= (ovf_q && !s2_first_q) || clamp;
    end
  end

  assign out_overflow = ovf_q;
`else
  assign acc_d        = acc_base + sum_ext;
  assign out_overflow = 1'b0;
`endif

  always_ff @(posedge clock) begin
    if (!reset) begin
      acc_q <= '0;
    end else if (s2_valid_q) begin
      acc_q <= acc_d;
    end
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q     <= ACC;
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
      first_q     <= 1'b1;
    end else begin
      case (state_q)
        ACC: begin
          in_ready_q <= 1'b1;
          if (accept) begin
            first_q <= 1'b0;
            if (in_last) begin
              state_q    <= DRAIN;
              in_ready_q <= 1'b0;
            end
          end
        end
        DRAIN: begin
          if (acc_last_q) begin
            state_q     <= OUT;
            out_valid_q <= 1'b1;
          end
        end
        OUT: begin
          if (out_ready) begin
            state_q     <= ACC;
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            first_q     <= 1'b1;
          end
        end
        default: state_q <= ACC;
      endcase
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign out_acc   = acc_q;

endmodule

// File: tb/tb_mac_dot_array.sv
// Self-checking bench for mac_dot_array: directed vectors plus random ones against an integer model.
module tb_mac_dot_array;

  localparam int LANES  = 4;
  localparam int DATA_W = 8;
  localparam int ACC_W  = 32;
  localparam longint MAXV = 64'sd2147483647;
  localparam longint MINV = -64'sd2147483648;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] in_data = '0;
  logic [31:0] in_weight = '0;
  logic        weight_signed = 1'b0;
  logic        in_last = 1'b0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] out_acc;
  logic        out_overflow;

  int     n_checks = 0;
  int     n_errs = 0;
  longint cyc = 0;
  longint t_last = 0;

  // Reference model state: running dot product of the current vector.
  longint mdl_acc = 0;
  bit     mdl_ovf = 1'b0;
  bit     mdl_first = 1'b1;

  mac_dot_array #(
    .LANES  (LANES),
    .DATA_W (DATA_W),
    .ACC_W  (ACC_W)
  ) dut (
    .clock         (clock),
    .reset         (reset),
    .in_valid      (in_valid),
    .in_ready      (in_ready),
    .in_data       (in_data),
    .in_weight     (in_weight),
    .weight_signed (weight_signed),
    .in_last       (in_last),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .out_acc       (out_acc),
    .out_overflow  (out_overflow)
  );

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errs++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", tag, obs, obs, exp, exp);
    end
  endtask

  function automatic longint beat_sum(input logic [31:0] d, input logic [31:0] w, input logic ws);
    longint s;
    longint a;
    longint b;
    s = 0;
    for (int i = 0; i < LANES; i++) begin
      a = longint'(d[8*i +: 8]);
      if (ws) b = longint'($signed(w[8*i +: 8]));
      else    b = longint'(w[8*i +: 8]);
      s += a * b;
    end
    return s;
  endfunction

  task automatic mdl_beat(input longint s);
    longint r;
    if (mdl_first) begin
      r = s;
      mdl_ovf = 1'b0;
    end else begin
      r = mdl_acc + s;
    end
    mdl_first = 1'b0;
`ifdef MAC_SATURATE_EN
    if (r > MAXV) begin
      r = MAXV;
      mdl_ovf = 1'b1;
    end else if (r < MINV) begin
      r = MINV;
      mdl_ovf = 1'b1;
    end
`else
    r = longint'($signed(r[31:0]));
`endif
    mdl_acc = r;
  endtask

  task automatic send_beats(input string tag, input int n, input logic [31:0] d,
                            input logic [31:0] w, input logic ws, input bit rnd,
                            input bit with_last);
    logic [31:0] dd;
    logic [31:0] ww;
    logic        wss;
    int          waitc;
    int          stalls;
    bit          timed_out;
    stalls = 0;
    timed_out = 1'b0;
    for (int b = 0; b < n; b++) begin
      dd = d;
      ww = w;
      wss = ws;
      if (rnd) begin
        dd = $urandom;
        ww = $urandom;
        wss = 1'($urandom_range(0, 1));
      end
      in_valid = 1'b1;
      in_data = dd;
      in_weight = ww;
      weight_signed = wss;
      in_last = with_last && (b == n - 1);
      waitc = 0;
      while (!in_ready && waitc < 50) begin
        @(negedge clock);
        waitc++;
      end
      if (!in_ready) begin
        check_eq({tag, "_accept_timeout"}, in_ready, 1);
        timed_out = 1'b1;
        break;
      end
      if (b > 0) stalls += waitc;
      mdl_beat(beat_sum(dd, ww, wss));
      t_last = cyc + 1;
      @(negedge clock);
    end
    in_valid = 1'b0;
    in_last = 1'b0;
    if (!timed_out) begin
      check_eq({tag, "_stalls"}, stalls, 0);
      if (with_last) check_eq({tag, "_rdy_drop"}, in_ready, 0);
    end
  endtask

  task automatic recv(input string tag, input int hold, output logic [31:0] got);
    int waitc;
    logic [31:0] exp_acc;
    exp_acc = mdl_acc[31:0];
    out_ready = 1'b0;
    waitc = 0;
    while (!out_valid && waitc < 20) begin
      @(negedge clock);
      waitc++;
    end
    check_eq({tag, "_valid"}, out_valid, 1);
    check_eq({tag, "_latency"}, cyc - t_last, 3);
    check_eq({tag, "_rdy_out"}, in_ready, 0);
    got = out_acc;
    for (int h = 0; h < hold; h++) begin
      @(negedge clock);
      check_eq({tag, "_hold_acc"}, out_acc, got);
      check_eq({tag, "_hold_valid"}, out_valid, 1);
      check_eq({tag, "_hold_rdy"}, in_ready, 0);
    end
    check_eq({tag, "_acc"}, out_acc, exp_acc);
    check_eq({tag, "_ovf"}, out_overflow, mdl_ovf);
    $display("vec %s: acc=%0d ovf=%0d (model %0d/%0d) hold=%0d", tag, $signed(out_acc),
             out_overflow, $signed(exp_acc), mdl_ovf, hold);
    out_ready = 1'b1;
    @(negedge clock);
    out_ready = 1'b0;
    mdl_first = 1'b1;
    check_eq({tag, "_valid_drop"}, out_valid, 0);
    check_eq({tag, "_rdy_back"}, in_ready, 1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] got;
    int          n;

    reset = 1'b0;
    repeat (3) @(negedge clock);
    check_eq("rst_valid", out_valid, 0);
    check_eq("rst_acc", out_acc, 0);
    check_eq("rst_ovf", out_overflow, 0);
    check_eq("rst_rdy", in_ready, 0);
    reset = 1'b1;
    @(negedge clock);
    check_eq("rst_rdy_release", in_ready, 1);

    send_beats("t1", 1, 32'h04030201, 32'h08070605, 1'b0, 1'b0, 1'b1);
    recv("t1", 0, got);
    check_eq("t1_lit", got, 70);

    send_beats("t2s", 1, 32'h0A0A0A0A, 32'h0403FEFF, 1'b1, 1'b0, 1'b1);
    recv("t2s", 0, got);
    check_eq("t2s_lit", got, 40);
    send_beats("t2u", 1, 32'h0A0A0A0A, 32'h0403FEFF, 1'b0, 1'b0, 1'b1);
    recv("t2u", 0, got);
    check_eq("t2u_lit", got, 5160);

    send_beats("t3", 80, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, 1'b0, 1'b1);
    recv("t3", 0, got);
    check_eq("t3_lit", got, 20808000);

    send_beats("t4a", 3, '0, '0, 1'b0, 1'b1, 1'b1);
    recv("t4a", 5, got);
    send_beats("t4b", 1, 32'h01010101, 32'h02020202, 1'b0, 1'b0, 1'b1);
    recv("t4b", 0, got);
    check_eq("t4b_lit", got, 8);

    for (int v = 0; v < 6; v++) begin
      n = $urandom_range(1, 6);
      send_beats($sformatf("rnd%0d", v), n, '0, '0, 1'b0, 1'b1, 1'b1);
      recv($sformatf("rnd%0d", v), $urandom_range(0, 2), got);
    end

    send_beats("t5", 16449, 32'hFFFFFFFF, 32'h80808080, 1'b1, 1'b0, 1'b1);
    recv("t5", 0, got);
`ifdef MAC_SATURATE_EN
    check_eq("t5_lit", got, 32'h80000000);
`else
    check_eq("t5_lit", got, 32'd2147385856);
`endif

    send_beats("t6pre", 3, '0, '0, 1'b0, 1'b1, 1'b0);
    reset = 1'b0;
    @(negedge clock);
    check_eq("t6_rst_valid", out_valid, 0);
    check_eq("t6_rst_rdy", in_ready, 0);
    check_eq("t6_rst_acc", out_acc, 0);
    reset = 1'b1;
    mdl_first = 1'b1;
    @(negedge clock);
    check_eq("t6_rdy_release", in_ready, 1);
    repeat (4) @(negedge clock);
    check_eq("t6_no_valid", out_valid, 0);
    send_beats("t6", 1, 32'h01010101, 32'h01010101, 1'b0, 1'b0, 1'b1);
    recv("t6", 0, got);
    check_eq("t6_lit", got, 4);

    $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
    $finish;
  end

endmodule

// File: doc/mac_dot_array.md
# mac_dot_array

Parametrised multi-lane dot-product engine, successor to the single-lane uint8/int32 MAC. Each accepted beat multiplies LANES uint8 activations by LANES uint8 or int8 weights, reduces the products through an adder tree, and accumulates them over a variable-length vector delimited by `in_last`. Results leave on a valid/ready output port. The block sits between the activation/weight streamers and the requantisation stage of the conv datapath. No explicit clear is needed: the first beat of each vector overwrites the accumulator.

## Interface
- `LANES`, default 4: parallel multiply lanes (power of two, ≥1).
- `DATA_W`, default 8: activation and weight width.
- `ACC_W`, default 32: accumulator and result width, two's complement.

Ports, clock and reset first:
- `clock`  in  1  single clock, rising edge.
- `reset`  in  1  synchronous, active-low (0 = reset).
- `in_valid`  in  1  input beat valid.
- `in_ready`  out  1  block accepts a beat.
- `in_data`  in  LANES*DATA_W  activations, unsigned; lane i at bits [i*DATA_W +: DATA_W].
- `in_weight`  in  LANES*DATA_W  weights, same packing.
- `weight_signed`  in  1  1 = weights are two's complement; 0 = unsigned. Sampled per beat.
- `in_last`  in  1  the beat is the final beat of the vector.
- `out_valid`  out  1  result available.
- `out_ready`  in  1  consumer takes the result.
- `out_acc`  out  ACC_W  signed dot-product result.
- `out_overflow`  out  1  saturation occurred in this vector. Tied to 0 without the saturation feature.

## Operation
- A beat is accepted when `in_valid && in_ready`.
- Per lane:
  - Activation is zero-extended to DATA_W+1 bits.
  - Weight is sign- or zero-extended to DATA_W+1 bits according to `weight_signed`.
  - The signed product is 2*DATA_W+2 bits.
- Tree sum width is 2*DATA_W+2+clog2(LANES). It is sign-extended to ACC_W before accumulation.
- The accumulator is signed ACC_W. The first beat after the result handshake (or after reset) loads the sum; subsequent beats add to it.
- States:
  - ACC: `in_ready`=1. Accepting `in_last` → DRAIN.
  - DRAIN: `in_ready`=0. Waits until the last beat leaves stage 3 → OUT.
  - OUT: `out_valid`=1. `out_ready`=1 → ACC.
- `out_acc` and `out_overflow` are held stable while `out_valid`=1 and `out_ready`=0.
- `in_ready` is 0 from the cycle after the `in_last` acceptance until the cycle after the output handshake.
- Reset mid-operation: pipeline, accumulator and state are cleared and the partial vector is discarded.
- Single-beat vectors (`in_last` on the first beat) are legal.

## Timing
- Pipeline stages:
  - Stage 1: product registers.
  - Stage 2: adder-tree register.
  - Stage 3: accumulator.
- `in_last` accepted at edge t → `out_valid` rises at edge t+3, meaning it is visible in the cycle after edge t+3.
- Output handshake at edge h → `in_ready`=1 after edge h. Minimum vector period is beats+4 cycles.
- Reset values:
  - `out_valid`=0, `out_acc`=0, `out_overflow`=0, state=ACC.
  - `in_ready`=0 while `reset`=0, then 1 in the first cycle after deassertion.
- `in_ready` is a registered-state decode with no combinational path from `out_ready`.

## Configuration
- `MAC_SATURATE_EN` defined:
  - Each accumulate clamps to [-2^(ACC_W-1), 2^(ACC_W-1)-1].
  - The first clamp in a vector sets sticky `out_overflow`, which clears on the next vector's first beat.
  - A clamped accumulator keeps accumulating from the clamp value.
- Undefined:
  - Accumulation wraps modulo 2^ACC_W.
  - `out_overflow` is constant 0 and no overflow logic is synthesised.

## Structure
- Shared package `mac_pkg`:
  - state enum `mac_state_e` {ACC, DRAIN, OUT}.
  - Width helper constants (product width, tree width).
  - Saturation bounds as functions of ACC_W.
- Sub-module `mac_dot_adder_tree`:
  - Parametrised LANES-input signed reduction with the stage-2 register.
  - Instantiated once.

## Test plan
Bench uses LANES=4, DATA_W=8, ACC_W=32.
1. Single beat, data {1,2,3,4}, weight {5,6,7,8}, unsigned, `in_last` → `out_acc`=70 exactly 3 edges after acceptance.
2. Data {10,10,10,10}, weight {0xFF,0xFE,3,4}:
   - `weight_signed`=1 → 40.
   - Same vector with `weight_signed`=0 → 5160.
3. 80 beats of all-255 × 255 unsigned → 20,808,000, with `in_ready`=0 only during DRAIN/OUT.
4. Hold `out_ready`=0 for 5 cycles → `out_acc` stable and `in_ready`=0. Next vector {1,1,1,1}×{2,2,2,2} → 8, with no residue from the prior vector.
5. Overflow: 16,449 beats of data 255, weight 0x80 signed (-130,560 per beat):
   - `MAC_SATURATE_EN` defined → `out_acc`=0x80000000, `out_overflow`=1.
   - Undefined → 2,147,385,856, `out_overflow`=0.
6. Drive `reset`=0 for one cycle after 3 beats of a vector → `out_valid` stays 0. The next vector {1,1,1,1}×{1,1,1,1} → 4.
